megabytebeat_mixer: RTL and testbench



---
 rtl/megabytebeat_pkg.sv | 9 +
 rtl/megabytebeat_pwm.sv | 15 +
 rtl/megabytebeat_mixer.sv | 118 +++++++++++
 tb/tb_megabytebeat_mixer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/megabytebeat_pkg.sv
// megabytebeat_pkg: mix-FSM states, accumulator sizing helper and dither LFSR constants shared by the mixer
package megabytebeat_pkg;
  typedef enum logic [1:0] {IDLE, MIX, OUT} mix_st_e;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  function automatic int acc_w(input int pcm_w, input int num_voices);
    return pcm_w + $clog2(num_voices);
  endfunction
endpackage

// File: rtl/megabytebeat_pwm.sv
// megabytebeat_pwm: registered PWM comparator against a shared free-running counter
module megabytebeat_pwm #(
  parameter int PCM_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PCM_W-1:0] cnt,
  input  logic [PCM_W-1:0] thr,
  output logic             pwm
);
  logic pwm_q, pwm_d;
  always_comb pwm_d = cnt < thr;
  always_ff @(posedge clk) pwm_q <= rst_n ? pwm_d : 1'b0;
  assign pwm = pwm_q;
endmodule

// File: rtl/megabytebeat_mixer.sv
// megabytebeat_mixer: N-voice bytebeat mixer with sample divider, voice handshake, sequential mix and PWM outputs
// Define MEGABYTEBEAT_MIXER_DITHER_EN to dither the mixed PWM threshold with a 16-bit LFSR.
module megabytebeat_mixer
  import megabytebeat_pkg::*;
#(
  parameter int NUM_VOICES = 8,
  parameter int PCM_W      = 8,
  parameter int DIV_W      = 12
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_VOICES*PCM_W-1:0] voice_pcm,
  input  logic [NUM_VOICES-1:0]       voice_vld,
  output logic [NUM_VOICES-1:0]       voice_rdy,
  input  logic [NUM_VOICES-1:0]       voice_en,
  input  logic [DIV_W-1:0]            div_sel,
  input  logic                        mix_mode,
  input  logic                        underrun_clr,
  output logic [PCM_W-1:0]            pcm_out,
  output logic                        pcm_out_vld,
  output logic                        pwm_out,
  output logic [NUM_VOICES-1:0]       pwm_voice,
  output logic [NUM_VOICES-1:0]       underrun
);
  localparam int LOG_N = $clog2(NUM_VOICES);
  localparam int ACC_W = acc_w(PCM_W, NUM_VOICES);
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic tick;
  logic [NUM_VOICES-1:0] rdy_q, rdy_d, urun_q, urun_d, xfer;
  logic [PCM_W-1:0] hold_q [NUM_VOICES];
  logic [PCM_W-1:0] hold_d [NUM_VOICES];
  logic [PCM_W-1:0] snap_q [NUM_VOICES];
  mix_st_e st_q;
  logic [LOG_N-1:0] v_q;
  logic [ACC_W-1:0] acc_q;
  logic [PCM_W-1:0] pcm_q, res, pc_q, pc_d, thr;
  logic vld_q;
  always_comb begin
    tick = cnt_q >= div_sel;
    cnt_d = tick ? '0 : cnt_q + DIV_W'(1);
    xfer = rdy_q & voice_vld;
    rdy_d = voice_en & ({NUM_VOICES{tick}} | (rdy_q & ~xfer));
    urun_d = (urun_q & ~{NUM_VOICES{underrun_clr}}) | ({NUM_VOICES{tick}} & rdy_q & ~xfer & voice_en);
    for (int i = 0; i < NUM_VOICES; i++) hold_d[i] = xfer[i] ? voice_pcm[i*PCM_W +: PCM_W] : hold_q[i];
    pc_d = pc_q + PCM_W'(1);
    res = mix_mode ? (|acc_q[ACC_W-1:PCM_W] ? '1 : acc_q[PCM_W-1:0]) : acc_q[ACC_W-1:LOG_N];
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      rdy_q <= '0;
      urun_q <= '0;
      pc_q <= '0;
      hold_q <= '{default: '0};
    end else begin
      cnt_q <= cnt_d;
      rdy_q <= rdy_d;
      urun_q <= urun_d;
      pc_q <= pc_d;
      hold_q <= hold_d;
    end
  end
  // The mix works on a snapshot taken at the tick, so it always sees the previous frame's samples.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q <= IDLE;
      v_q <= '0;
      acc_q <= '0;
      pcm_q <= '0;
      vld_q <= 1'b0;
      snap_q <= '{default: '0};
    end else begin
      vld_q <= 1'b0;
      case (st_q)
        IDLE: if (tick) begin
          acc_q <= '0;
          v_q <= '0;
          snap_q <= hold_q;
          st_q <= MIX;
        end
        MIX: begin
          acc_q <= acc_q + (voice_en[v_q] ? ACC_W'(snap_q[v_q]) : '0);
          v_q <= v_q + LOG_N'(1);
          if (&v_q) st_q <= OUT;
        end
        OUT: begin
          pcm_q <= res;
          vld_q <= 1'b1;
          st_q <= IDLE;
        end
        default: st_q <= IDLE;
      endcase
    end
  end
`ifdef MEGABYTEBEAT_MIXER_DITHER_EN
  localparam int TW = PCM_W + 1;
  logic [15:0] lfsr_q, lfsr_d;
  logic [PCM_W:0] thr_sum;
  always_comb begin
    lfsr_d = &pc_q ? ((lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0)) : lfsr_q;
    thr_sum = {1'b0, pcm_q} + TW'(lfsr_q[0]);
    thr = thr_sum[PCM_W] ? '1 : thr_sum[PCM_W-1:0];
  end
  always_ff @(posedge clk) lfsr_q <= rst_n ? lfsr_d : LFSR_SEED;
`else
  assign thr = pcm_q;
`endif
  megabytebeat_pwm #(.PCM_W(PCM_W)) u_pwm_mix (.clk(clk), .rst_n(rst_n), .cnt(pc_q), .thr(thr), .pwm(pwm_out));
  for (genvar i = 0; i < NUM_VOICES; i++) begin : g_voice
    megabytebeat_pwm #(.PCM_W(PCM_W)) u_pwm (
      .clk(clk), .rst_n(rst_n), .cnt(pc_q), .thr(voice_en[i] ? hold_q[i] : '0), .pwm(pwm_voice[i])
    );
  end
  assign voice_rdy = rdy_q;
  assign underrun = urun_q;
  assign pcm_out = pcm_q;
  assign pcm_out_vld = vld_q;
endmodule

// File: tb/tb_megabytebeat_mixer.sv
// tb_megabytebeat_mixer: randomized self-checking bench against a frame-level behavioural model of the mixer
module tb_megabytebeat_mixer;
  localparam int NV = 8;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [NV*8-1:0] voice_pcm = '0;
  logic [NV-1:0] voice_vld = '0, voice_en = '0;
  logic [NV-1:0] voice_rdy, pwm_voice, underrun;
  logic [11:0] div_sel = '0;
  logic mix_mode = 1'b0, underrun_clr = 1'b0;
  logic [7:0] pcm_out;
  logic pcm_out_vld, pwm_out;
  int checks = 0, errors = 0, cycle = 0;

  megabytebeat_mixer dut (
    .clk(clk), .rst_n(rst_n), .voice_pcm(voice_pcm), .voice_vld(voice_vld), .voice_rdy(voice_rdy),
    .voice_en(voice_en), .div_sel(div_sel), .mix_mode(mix_mode), .underrun_clr(underrun_clr),
    .pcm_out(pcm_out), .pcm_out_vld(pcm_out_vld), .pwm_out(pwm_out), .pwm_voice(pwm_voice), .underrun(underrun)
  );

  always #5 clk = ~clk;

  int m_cnt, m_t, m_acc;
  bit m_busy, m_vld, m_pwm;
  logic [7:0] m_rdy, m_urun, m_pwmv, m_pcm, m_pc;
  logic [7:0] m_hold [NV];
  logic [7:0] m_snap [NV];

  // One clock: advance the model with the inputs seen at the edge, then settle 1 time unit.
  task automatic cyc();
    logic [NV-1:0] xfer;
    bit tick;
    int ph;
    @(posedge clk);
    if (!rst_n) begin
      m_cnt = 0; m_busy = 0; m_vld = 0; m_pwm = 0; m_acc = 0;
      m_rdy = '0; m_urun = '0; m_pwmv = '0; m_pcm = '0; m_pc = '0;
      for (int i = 0; i < NV; i++) m_hold[i] = '0;
    end else begin
      tick = m_cnt >= int'(div_sel);
      xfer = m_rdy & voice_vld;
      m_pwm = m_pc < m_pcm;
      for (int i = 0; i < NV; i++) m_pwmv[i] = voice_en[i] && (m_pc < m_hold[i]);
      m_pc = m_pc + 8'd1;
      m_vld = 0;
      if (m_busy) begin
        ph = cycle - m_t;
        if (ph <= NV) m_acc += voice_en[ph-1] ? int'(m_snap[ph-1]) : 0;
        else begin
          m_pcm = mix_mode ? ((m_acc > 255) ? 8'hFF : 8'(m_acc)) : 8'(m_acc / NV);
          m_vld = 1;
          m_busy = 0;
        end
      end else if (tick) begin
        m_busy = 1; m_t = cycle; m_acc = 0; m_snap = m_hold;
      end
      if (underrun_clr) m_urun = '0;
      for (int i = 0; i < NV; i++) begin
        if (!voice_en[i]) m_rdy[i] = 0;
        else if (tick) begin
          if (m_rdy[i] && !xfer[i]) m_urun[i] = 1;
          m_rdy[i] = 1;
        end else if (xfer[i]) m_rdy[i] = 0;
        if (xfer[i]) m_hold[i] = voice_pcm[i*8 +: 8];
      end
      m_cnt = tick ? 0 : m_cnt + 1;
    end
    cycle++;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    for (int k = 0; k < 3; k++) begin
      voice_pcm = {$urandom, $urandom}; voice_vld = 8'($urandom); voice_en = 8'($urandom);
      div_sel = 12'($urandom); mix_mode = 1'($urandom); underrun_clr = 1'($urandom);
      cyc();
      checks++;
      if ({voice_rdy, underrun, pcm_out, pcm_out_vld, pwm_out, pwm_voice} !== '0) begin
        errors++;
        $display("FAIL reset_outputs: rdy=%h urun=%h pcm=%h vld=%b pwm=%b pwmv=%h, want all 0",
                 voice_rdy, underrun, pcm_out, pcm_out_vld, pwm_out, pwm_voice);
      end
    end
    voice_pcm = {NV{8'h10}}; voice_vld = '1; voice_en = '1; div_sel = 12'd15; mix_mode = 0; underrun_clr = 0;
    rst_n = 1;
    cyc();
    checks++;
    if (voice_rdy !== 8'h00) begin errors++; $display("FAIL reset_rdy_release: got %h want 00", voice_rdy); end
  endtask

  task automatic test_average();
    int nf = 0, last = -1;
    for (int k = 0; k < 90; k++) begin
      cyc();
      checks++;
      if (pcm_out_vld !== m_vld || pcm_out !== m_pcm || voice_rdy !== m_rdy || underrun !== m_urun) begin
        errors++;
        $display("FAIL avg_model @%0d: vld=%b pcm=%h rdy=%h urun=%h want vld=%b pcm=%h rdy=%h urun=%h",
                 cycle, pcm_out_vld, pcm_out, voice_rdy, underrun, m_vld, m_pcm, m_rdy, m_urun);
      end
      if (pcm_out_vld === 1'b1) begin
        nf++;
        checks++;
        if (pcm_out !== (nf == 1 ? 8'h00 : 8'h10)) begin
          errors++; $display("FAIL avg_frame%0d: got %h want %h", nf, pcm_out, nf == 1 ? 8'h00 : 8'h10);
        end
        if (last >= 0) begin
          checks++;
          if (cycle - last != 16) begin errors++; $display("FAIL avg_interval: got %0d want 16", cycle - last); end
        end
        last = cycle;
      end
    end
    checks++;
    if (nf < 4 || underrun !== 8'h00) begin
      errors++; $display("FAIL avg_summary: frames=%0d urun=%h want >=4 frames and urun 00", nf, underrun);
    end
  endtask

  task automatic test_mode();
    voice_pcm = {NV{8'h40}};
    for (int m = 1; m >= 0; m--) begin
      int nf = 0;
      mix_mode = 1'(m);
      for (int k = 0; k < 200 && nf < 3; k++) begin
        cyc();
        checks++;
        if (pcm_out_vld !== m_vld || pcm_out !== m_pcm) begin
          errors++;
          $display("FAIL mode_model @%0d: vld=%b pcm=%h want vld=%b pcm=%h", cycle, pcm_out_vld, pcm_out, m_vld, m_pcm);
        end
        if (pcm_out_vld === 1'b1) nf++;
      end
      checks++;
      if (nf < 3 || pcm_out !== (m ? 8'hFF : 8'h40)) begin
        errors++; $display("FAIL mode%0d_result: frames=%0d got %h want %h", m, nf, pcm_out, m ? 8'hFF : 8'h40);
      end
    end
  endtask

  task automatic test_underrun();
    voice_pcm = {NV{8'h10}}; voice_vld = '1; mix_mode = 0;
    repeat (40) cyc();
    voice_vld[3] = 0; voice_pcm[3*8 +: 8] = 8'hF0;
    for (int k = 0; k < 60; k++) begin
      cyc();
      checks++;
      if (underrun !== m_urun || voice_rdy !== m_rdy || pcm_out !== m_pcm) begin
        errors++;
        $display("FAIL urun_model @%0d: urun=%h rdy=%h pcm=%h want urun=%h rdy=%h pcm=%h",
                 cycle, underrun, voice_rdy, pcm_out, m_urun, m_rdy, m_pcm);
      end
    end
    checks++;
    if (underrun !== 8'h08 || pcm_out !== 8'h10) begin
      errors++; $display("FAIL urun_set: urun=%h pcm=%h want 08 and 10", underrun, pcm_out);
    end
    for (int k = 0; k < 64 && m_cnt >= int'(div_sel); k++) cyc();
    underrun_clr = 1;
    cyc();
    underrun_clr = 0;
    checks++;
    if (underrun !== 8'h00 || m_urun !== 8'h00) begin
      errors++; $display("FAIL urun_clear: got %h want 00", underrun);
    end
    for (int k = 0; k < 64 && m_cnt < int'(div_sel); k++) cyc();
    underrun_clr = 1;
    cyc();
    underrun_clr = 0;
    checks++;
    if (underrun !== 8'h08 || m_urun !== 8'h08) begin
      errors++; $display("FAIL urun_set_wins: got %h want 08", underrun);
    end
    voice_vld[3] = 1; voice_pcm[3*8 +: 8] = 8'h10; underrun_clr = 1;
    cyc();
    underrun_clr = 0;
  endtask

  task automatic test_single();
    int nf = 0, hi = 0, hv = 0, stray = 0;
    voice_en = 8'h01; voice_pcm[7:0] = 8'h80; mix_mode = 1;
    for (int k = 0; k < 200 && nf < 3; k++) begin
      cyc();
      if (pcm_out_vld === 1'b1) nf++;
    end
    checks++;
    if (nf < 3 || pcm_out !== 8'h80) begin
      errors++; $display("FAIL single_pcm: frames=%0d got %h want 80", nf, pcm_out);
    end
    for (int k = 0; k < 256; k++) begin
      cyc();
      checks++;
      if (pwm_out !== m_pwm || pwm_voice !== m_pwmv) begin
        errors++;
        $display("FAIL single_pwm_model @%0d: pwm=%b pwmv=%h want pwm=%b pwmv=%h", cycle, pwm_out, pwm_voice, m_pwm, m_pwmv);
      end
      hi += int'(pwm_out === 1'b1);
      hv += int'(pwm_voice[0] === 1'b1);
      stray += int'((pwm_voice & 8'hFE) !== 8'h00);
    end
    checks++;
    if (hi != 128 || hv != 128 || stray != 0) begin
      errors++; $display("FAIL single_pwm_duty: pwm=%0d voice0=%0d stray=%0d want 128 128 0", hi, hv, stray);
    end
  endtask

  task automatic test_short_period();
    int last = -1, rdy_hits = 0;
    div_sel = 12'd3; voice_en = '1; voice_pcm = {NV{8'h10}}; voice_vld = '1; mix_mode = 0;
    repeat (30) cyc();
    for (int k = 0; k < 60; k++) begin
      cyc();
      checks++;
      if (pcm_out_vld !== m_vld || pcm_out !== m_pcm || voice_rdy !== m_rdy) begin
        errors++;
        $display("FAIL short_model @%0d: vld=%b pcm=%h rdy=%h want vld=%b pcm=%h rdy=%h",
                 cycle, pcm_out_vld, pcm_out, voice_rdy, m_vld, m_pcm, m_rdy);
      end
      rdy_hits += int'(voice_rdy === 8'hFF);
      if (pcm_out_vld === 1'b1) begin
        if (last >= 0) begin
          checks++;
          if (cycle - last != 12) begin errors++; $display("FAIL short_interval: got %0d want 12", cycle - last); end
        end
        last = cycle;
      end
    end
    checks++;
    if (rdy_hits != 15 || last < 0) begin
      errors++; $display("FAIL short_handshakes: rdy cycles=%0d want 15", rdy_hits);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      if (k % 150 == 0) div_sel = 12'($urandom_range(20, 0));
      if (k % 50 == 0) voice_en = 8'($urandom);
      if (k % 37 == 0) mix_mode = 1'($urandom);
      voice_pcm = {$urandom, $urandom};
      voice_vld = 8'($urandom) | 8'($urandom);
      underrun_clr = ($urandom_range(31, 0) == 0);
      rst_n = (k != 300);
      cyc();
      checks++;
      if (pcm_out_vld !== m_vld || pcm_out !== m_pcm || voice_rdy !== m_rdy || underrun !== m_urun ||
          pwm_out !== m_pwm || pwm_voice !== m_pwmv) begin
        errors++;
        $display("FAIL rand_model @%0d: vld=%b pcm=%h rdy=%h urun=%h pwm=%b pwmv=%h want %b %h %h %h %b %h",
                 cycle, pcm_out_vld, pcm_out, voice_rdy, underrun, pwm_out, pwm_voice,
                 m_vld, m_pcm, m_rdy, m_urun, m_pwm, m_pwmv);
      end
    end
    rst_n = 1; underrun_clr = 0;
  endtask

  initial begin
    test_reset();
    test_average();
    test_mode();
    test_underrun();
    test_single();
    test_short_period();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
